// File: rtl/mul_div_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package mul_div_unit_pkg;

  typedef logic [31:0] Vec32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } MdOp;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } MdState;

  localparam int unsigned MD_ITERATIONS = 32;

  function automatic Vec32 magnitude(input Vec32 value, input logic isSigned);
    return (isSigned && value[31]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import mul_div_unit_pkg::*;
(
  input  logic [31:0] remainder,
  input  logic        dividendBit,
  input  logic [31:0] divisor,
  output logic [31:0] newRemainder,
  output logic        quotientBit
);

  logic [32:0] shifted;
  Vec32        diff;

  always_comb begin
    shifted      = {remainder, dividendBit};
    // The partial remainder stays below the divisor, so a 32-bit difference is exact when it fits.
    diff         = shifted[31:0] - divisor;
    quotientBit  = (shifted >= {1'b0, divisor});
    newRemainder = quotientBit ? diff : shifted[31:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  MdState      stateQ, stateD;
  logic [5:0]  cntQ, cntD;
  logic        isDivQ, isDivD;
  logic        signAQ, signAD, signBQ, signBD;
  Vec32        magAQ, magAD, magBQ, magBD, rawAQ, rawAD;
  logic [63:0] accQ, accD;
  Vec32        hiQ, hiD, loQ, loD;
  logic        doneQ, doneD;

  logic        startSigned, startIsDiv;
  logic [32:0] mulSum;
  logic [63:0] mulNext, product;
  Vec32        divRem, quotient, remainder;
  logic        divBit;

  div_step divStep (
    .remainder    (accQ[63:32]),
    .dividendBit  (accQ[31]),
    .divisor      (magBQ),
    .newRemainder (divRem),
    .quotientBit  (divBit)
  );

  // Accumulator layout: multiply keeps {partial product, remaining multiplier bits};
  // divide keeps {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign mulSum  = {1'b0, accQ[63:32]} + (accQ[0] ? {1'b0, magAQ} : 33'd0);
  assign mulNext = {mulSum, accQ[31:1]};

  assign product   = (signAQ ^ signBQ) ? -accQ : accQ;
  assign quotient  = (signAQ ^ signBQ) ? -accQ[31:0] : accQ[31:0];
  assign remainder = signAQ ? -accQ[63:32] : accQ[63:32];

  assign startSigned = (op == MD_MULT) || (op == MD_DIV);
  assign startIsDiv  = (op == MD_DIV) || (op == MD_DIVU);

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    isDivD = isDivQ;
    signAD = signAQ;
    signBD = signBQ;
    magAD  = magAQ;
    magBD  = magBQ;
    rawAD  = rawAQ;
    accD   = accQ;
    hiD    = hiQ;
    loD    = loQ;
    doneD  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              isDivD = startIsDiv;
              signAD = startSigned & operandA[31];
              signBD = startSigned & operandB[31];
              magAD  = magnitude(operandA, startSigned);
              magBD  = magnitude(operandB, startSigned);
              rawAD  = operandA;
              accD   = {32'd0, startIsDiv ? magnitude(operandA, startSigned)
                                          : magnitude(operandB, startSigned)};
              cntD   = '0;
              stateD = StRun;
            end
            MD_MTHI: hiD = operandA;
            MD_MTLO: loD = operandA;
            default: ;
          endcase
        end
      end
      StRun: begin
        accD = isDivQ ? {divRem, accQ[30:0], divBit} : mulNext;
        cntD = cntQ + 6'd1;
        if (cntQ == 6'(MD_ITERATIONS - 1)) stateD = StFix;
      end
      StFix: begin
        if (!isDivQ) begin
          {hiD, loD} = product;
        end else if (magBQ == '0) begin
          loD = '1;
          hiD = rawAQ;
        end else begin
          loD = quotient;
          hiD = remainder;
        end
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      isDivQ <= 1'b0;
      signAQ <= 1'b0;
      signBQ <= 1'b0;
      magAQ  <= '0;
      magBQ  <= '0;
      rawAQ  <= '0;
      accQ   <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      isDivQ <= isDivD;
      signAQ <= signAD;
      signBQ <= signBD;
      magAQ  <= magAD;
      magBQ  <= magBD;
      rawAQ  <= rawAD;
      accQ   <= accD;
      hiQ    <= hiD;
      loQ    <= loD;
      doneQ  <= doneD;
    end
  end

  assign busy = (stateQ != StIdle);
  assign done = doneQ;
  assign hi   = hiQ;
  assign lo   = loQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference of HI/LO.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mHi, mLo;

  mul_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the new {HI, LO} given the op, operands and the previous {HI, LO}.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] prev);
    longint          sq, sr;
    longint unsigned up;
    logic [63:0]     r;
    r = prev;
    case (o)
      3'd0: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        r  = 64'(sq);
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        r  = up;
      end
      3'd2: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFFFFFF};
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd4: r[63:32] = a;
      3'd5: r[31:0] = a;
      default: ;
    endcase
    return r;
  endfunction

  task automatic runMd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int injectAt, input string tag);
    logic [63:0] expect_;
    int          busyCycles;
    bit          seenDone;
    expect_ = refModel(o, a, b, {mHi, mLo});
    @(negedge clock);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(negedge clock);
    start = 1'b0;
    busyCycles = 0;
    seenDone   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        seenDone = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      if (i == 16) check({tag, " hi held"}, hi, mHi);
      if (i == injectAt) begin
        start = 1'b1; op = 3'd1; operandA = 32'd2; operandB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(seenDone), 32'd1);
    check({tag, " busy cycles"}, 32'(busyCycles), 32'd33);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, expect_[63:32]);
    check({tag, " lo"}, lo, expect_[31:0]);
    mHi = expect_[63:32];
    mLo = expect_[31:0];
    @(negedge clock);
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  task automatic runSingle(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    logic [63:0] expect_;
    expect_ = refModel(o, a, b, {mHi, mLo});
    @(negedge clock);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(negedge clock);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " hi"}, hi, expect_[63:32]);
    check({tag, " lo"}, lo, expect_[31:0]);
    mHi = expect_[63:32];
    mLo = expect_[31:0];
  endtask

  initial begin
    bit          sawDone;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; operandA = '0; operandB = '0;
    mHi = '0; mLo = '0;
    repeat (2) @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;

    runMd(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu max");
    runMd(3'd0, 32'hFFFFFFFD, 32'd5, 0, "mult neg");
    runMd(3'd2, 32'hFFFFFFF9, 32'd2, 0, "div neg");
    runMd(3'd3, 32'd7, 32'd2, 0, "divu small");
    runMd(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, "div overflow");
    runMd(3'd2, 32'h12345678, 32'd0, 0, "div by zero");
    runMd(3'd3, 32'd100, 32'd7, 5, "divu ignore start");
    runSingle(3'd4, 32'hDEADBEEF, 32'd0, "mthi");
    runSingle(3'd5, 32'hCAFEF00D, 32'd0, "mtlo");
    runSingle(3'd6, 32'h11111111, 32'd2, "reserved6");
    runSingle(3'd7, 32'h22222222, 32'd3, "reserved7");

    // Abort a divide partway through with reset.
    @(negedge clock);
    start = 1'b1; op = 3'd2; operandA = 32'd1000; operandB = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    mHi = '0; mLo = '0;
    sawDone = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) sawDone = 1'b1;
      @(negedge clock);
    end
    check("abort quiet", 32'(sawDone), 32'd0);
    runMd(3'd0, 32'd6, 32'd7, 0, "mult after abort");

    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (rop <= 3'd3) runMd(rop, ra, rb, 0, $sformatf("rand%0d op%0d", n, rop));
      else runSingle(rop, ra, rb, $sformatf("rand%0d op%0d", n, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
